// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency instruction
// memory and feeds {instruction, PC+4, valid} to the IF/ID register.
module if_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            valid_out,
    output logic [XLEN-1:0] ins_out,
    output logic [XLEN-1:0] pc_out
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] redir_pc_reg, redir_pc_next;
    logic            valid_reg, valid_next;
    logic [XLEN-1:0] ins_reg, ins_next;
    logic [XLEN-1:0] pc_out_reg, pc_out_next;
    logic [XLEN-1:0] skid_ins_reg, skid_ins_next;
    logic [XLEN-1:0] skid_pc_reg, skid_pc_next;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_aligned;
    logic            slot_free;

    assign pc_plus4         = pc_reg + WORD_BYTES;
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign slot_free        = !valid_reg || !stall;

    // DRAIN keeps requesting the old address: a request is never withdrawn.
    assign imem_req  = (state_reg != HOLD);
    assign imem_addr = pc_reg;

    assign valid_out = valid_reg;
    assign ins_out   = ins_reg;
    assign pc_out    = pc_out_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= FETCH;
            pc_reg       <= RESET_PC;
            redir_pc_reg <= '0;
            valid_reg    <= 1'b0;
            ins_reg      <= '0;
            pc_out_reg   <= '0;
            skid_ins_reg <= '0;
            skid_pc_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            redir_pc_reg <= redir_pc_next;
            valid_reg    <= valid_next;
            ins_reg      <= ins_next;
            pc_out_reg   <= pc_out_next;
            skid_ins_reg <= skid_ins_next;
            skid_pc_reg  <= skid_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        redir_pc_next = redir_pc_reg;
        valid_next    = valid_reg;
        ins_next      = ins_reg;
        pc_out_next   = pc_out_reg;
        skid_ins_next = skid_ins_reg;
        skid_pc_next  = skid_pc_reg;

        case (state_reg)
            FETCH: begin
                if (redirect_valid) begin
                    valid_next = 1'b0;
                    if (imem_ready) begin
                        pc_next = redirect_aligned;
                    end else begin
                        redir_pc_next = redirect_aligned;
                        state_next    = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_next = pc_plus4;
                    if (slot_free) begin
                        ins_next    = imem_rdata;
                        pc_out_next = pc_plus4;
                        valid_next  = 1'b1;
                    end else begin
                        // Output slot is held by a stall: park the word in the skid.
                        skid_ins_next = imem_rdata;
                        skid_pc_next  = pc_plus4;
                        state_next    = HOLD;
                    end
                end else if (!stall) begin
                    valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    valid_next = 1'b0;
                    pc_next    = redirect_aligned;
                    state_next = FETCH;
                end else if (!stall) begin
                    ins_next    = skid_ins_reg;
                    pc_out_next = skid_pc_reg;
                    valid_next  = 1'b1;
                    state_next  = FETCH;
                end
            end

            DRAIN: begin
                valid_next = 1'b0;
                if (redirect_valid) begin
                    redir_pc_next = redirect_aligned;
                end
                if (imem_ready) begin
                    // The latest redirect wins even if it lands on the completing cycle.
                    pc_next    = redirect_valid ? redirect_aligned : redir_pc_reg;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
                valid_next = 1'b0;
            end
        endcase
    end

endmodule
